pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder: WIDTH-bit A + B + carry-in, split into STAGES equal slices, one slice resolved per pipeline stage.
- Successor to the single-bit full-adder cell, which it uses as its bit primitive.
- Valid/ready streaming interface on both sides; sustains one operation per cycle, full back-pressure.
- Sits in the datapath between operand producers (register file / accumulator paths) and the result consumer.

---
 rtl/pipelined_adder_pkg.sv | 25 ++
 rtl/add_slice.sv | 27 ++
 rtl/pipelined_adder.sv | 127 ++++++++++++
 tb/tb_pipelined_adder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for pipelined_adder: slice sizing, a split sanity check,
// the full-adder bit cell and the per-stage control record.
package pipelined_adder_pkg;

   function automatic bit split_ok(input int unsigned width, input int unsigned stages);
      return (stages != 0) && (stages <= width) && ((width % stages) == 0);
   endfunction

   function automatic int unsigned CHUNK_OF(input int unsigned width, input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   // Full-adder bit cell, returns {cout, sum}
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
      return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
   endfunction

   // Per-stage control record; partial sums and pending operands have
   // stage-dependent widths and live beside it in the pipeline.
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

endpackage

// File: rtl/add_slice.sv
// CHUNK-bit combinational ripple-carry slice built from the full-adder cell.
module add_slice
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum_c,
   output logic             cout_c
);

   logic [CHUNK:0] carry;

   always_comb begin
      carry    = '0;
      sum_c    = '0;
      carry[0] = cin;
      for (int i = 0; i < int'(CHUNK); i++) begin
         {carry[i+1], sum_c[i]} = full_add(a[i], b[i], carry[i]);
      end
   end

   assign cout_c = carry[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, one CHUNK-bit slice resolved per stage.
// Optional signed-overflow output enabled by PIPELINED_ADDER_OVF_EN.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned CHUNK = CHUNK_OF(WIDTH, STAGES);

   if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
      $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
   end

   logic              adv;
   stage_ctl_t        ctl_q [STAGES];
   logic [WIDTH-1:0]  slice_sum;
   logic [STAGES-1:0] slice_cout;

   // Whole pipeline moves together; stalls only when the output is held
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(STAGES); k++) ctl_q[k] <= '0;
      end else if (adv) begin
         ctl_q[0] <= '{valid: in_valid, carry: slice_cout[0]};
         for (int k = 1; k < int'(STAGES); k++) begin
            ctl_q[k] <= '{valid: ctl_q[k-1].valid, carry: slice_cout[k]};
         end
      end
   end

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      localparam int unsigned LO  = k * CHUNK;
      localparam int unsigned REM = WIDTH - LO;

      logic [REM-1:0]      a_in;
      logic [REM-1:0]      b_in;
      logic                c_in;
      logic [LO+CHUNK-1:0] sum_q;

      // Stage 0 takes the port operands; later stages take the pending upper slices
      if (k == 0) begin : g_src
         assign a_in = in_a;
         assign b_in = in_b;
         assign c_in = in_cin;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   sum_q <= '0;
            else if (adv) sum_q <= slice_sum[CHUNK-1:0];
         end
      end else begin : g_src
         assign a_in = g_stage[k-1].g_pend.a_q;
         assign b_in = g_stage[k-1].g_pend.b_q;
         assign c_in = ctl_q[k-1].carry;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   sum_q <= '0;
            else if (adv) sum_q <= {slice_sum[LO +: CHUNK], g_stage[k-1].sum_q};
         end
      end

      add_slice #(.CHUNK(CHUNK)) u_slice (
         .a      (a_in[CHUNK-1:0]),
         .b      (b_in[CHUNK-1:0]),
         .cin    (c_in),
         .sum_c  (slice_sum[LO +: CHUNK]),
         .cout_c (slice_cout[k])
      );

      if (k < int'(STAGES) - 1) begin : g_pend
         logic [REM-CHUNK-1:0] a_q;
         logic [REM-CHUNK-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_in[REM-1:CHUNK];
               b_q <= b_in[REM-1:CHUNK];
            end
         end
      end
   end

   assign out_valid = ctl_q[STAGES-1].valid;
   assign out_cout  = ctl_q[STAGES-1].carry;
   assign out_sum   = g_stage[STAGES-1].sum_q;

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q;
   logic a_msb;
   logic b_msb;

   assign a_msb = g_stage[STAGES-1].a_in[CHUNK-1];
   assign b_msb = g_stage[STAGES-1].b_in[CHUNK-1];

   // Like-signed operands producing an opposite-signed sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ovf_q <= 1'b0;
      else if (adv) ovf_q <= (a_msb == b_msb) && (slice_sum[WIDTH-1] != a_msb);
   end

   assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: an 8-bit/2-stage and a 32-bit/4-stage instance.
module tb_pipelined_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       v8, r8, c8, ov8, or8, co8, ovf8;
   logic [7:0] a8, b8, s8;
   logic        v32, r32, c32, ov32, or32, co32, ovf32;
   logic [31:0] a32, b32, s32;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
      .in_cin(c8), .out_valid(ov8), .out_ready(or8), .out_sum(s8), .out_cout(co8)
`ifdef PIPELINED_ADDER_OVF_EN
      , .out_ovf(ovf8)
`endif
   );

   pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32),
      .in_cin(c32), .out_valid(ov32), .out_ready(or32), .out_sum(s32), .out_cout(co32)
`ifdef PIPELINED_ADDER_OVF_EN
      , .out_ovf(ovf32)
`endif
   );

`ifndef PIPELINED_ADDER_OVF_EN
   assign ovf8  = 1'b0;
   assign ovf32 = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] exp_q[$];
   int         n_out = 0;
   int         cyc = 0;
   int         out_first = 0;
   int         out_last = 0;
   logic       hold_pend = 1'b0;
   logic [7:0] hold_sum = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One cycle on the 8-bit instance: drive at negedge, score, advance to next negedge
   task automatic cycle8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic ordy);
      logic [8:0] e;
      v8 = iv; a8 = a; b8 = b; c8 = c; or8 = ordy;
      #1;
      if (hold_pend) begin
         check("hold_valid", 64'(ov8), 64'd1);
         check("hold_sum", 64'(s8), 64'(hold_sum));
      end
      if (ov8 && !or8) check("stall_in_ready", 64'(r8), 64'd0);
      if (v8 && r8) exp_q.push_back(9'(a) + 9'(b) + 9'(c));
      if (ov8 && or8) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(ov8), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("stream_sum", 64'(s8), 64'(e[7:0]));
            check("stream_cout", 64'(co8), 64'(e[8]));
            if (n_out == 0) out_first = cyc;
            out_last = cyc;
            n_out++;
         end
      end
      hold_pend = ov8 && !or8;
      hold_sum  = s8;
      cyc++;
      @(negedge clk);
   endtask

   // Single beat on the 8-bit instance with exact 2-cycle latency check
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
      v8 = 1'b1; a8 = a; b8 = b; c8 = c; or8 = 1'b1;
      #1 check({tag, "_in_ready"}, 64'(r8), 64'd1);
      @(negedge clk);
      v8 = 1'b0;
      check({tag, "_early"}, 64'(ov8), 64'd0);
      @(negedge clk);
      check({tag, "_valid"}, 64'(ov8), 64'd1);
      check({tag, "_sum"}, 64'(s8), 64'(es));
      check({tag, "_cout"}, 64'(co8), 64'(ec));
`ifdef PIPELINED_ADDER_OVF_EN
      check({tag, "_ovf"}, 64'(ovf8), 64'(eo));
`else
      if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
      @(negedge clk);
      check({tag, "_drop"}, 64'(ov8), 64'd0);
   endtask

   // Single beat on the 32-bit instance with exact 4-cycle latency check
   task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] es, input logic ec, input logic eo);
      v32 = 1'b1; a32 = a; b32 = b; c32 = c; or32 = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         v32 = 1'b0;
         check({tag, "_early"}, 64'(ov32), 64'd0);
      end
      @(negedge clk);
      check({tag, "_valid"}, 64'(ov32), 64'd1);
      check({tag, "_sum"}, 64'(s32), 64'(es));
      check({tag, "_cout"}, 64'(co32), 64'(ec));
`ifdef PIPELINED_ADDER_OVF_EN
      check({tag, "_ovf"}, 64'(ovf32), 64'(eo));
`else
      if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
      @(negedge clk);
      check({tag, "_drop"}, 64'(ov32), 64'd0);
   endtask

   initial begin
      v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; or8 = 1'b1;
      v32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; or32 = 1'b1;

      #12;
      check("rst_valid8", 64'(ov8), 64'd0);
      check("rst_sum8", 64'(s8), 64'd0);
      check("rst_cout8", 64'(co8), 64'd0);
      check("rst_in_ready8", 64'(r8), 64'd1);
      check("rst_valid32", 64'(ov32), 64'd0);
      check("rst_sum32", 64'(s32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run8("add_3c_55", 8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1);
      run8("wrap_ff_00_1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run8("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run8("neg_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // Back-to-back stream against the golden queue
      n_out = 0;
      for (int i = 0; i < 16; i++)
         cycle8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 4; i++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("stream_count", 64'(n_out), 64'd16);
      check("stream_contiguous", 64'(out_last - out_first), 64'd15);
      check("stream_drained", 64'(exp_q.size()), 64'd0);

      // Back-pressure: fill, stall five cycles with input pending, release, drain
      n_out = 0;
      for (int i = 0; i < 3; i++)
         cycle8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         cycle8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         cycle8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("stall_count", 64'(n_out), 64'd6);
      check("stall_drained", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset with beats in flight
      cycle8(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
      cycle8(1'b1, 8'h40, 8'h05, 1'b1, 1'b1);
      v8 = 1'b0;
      #2;
      check("pre_reset_valid", 64'(ov8), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(ov8), 64'd0);
      check("mid_rst_sum", 64'(s8), 64'd0);
      check("mid_rst_cout", 64'(co8), 64'd0);
      exp_q.delete();
      hold_pend = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_out = 0;
      for (int i = 0; i < 5; i++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("no_stale_beats", 64'(n_out), 64'd0);
      run8("post_reset_01_02", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

      // Default geometry: carry ripple across every slice boundary
      run32("w32_ones_plus_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run32("w32_mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
      run32("w32_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
